// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core-wide widths and the data-memory responder state type.
//   XLEN        - architectural register width
//   ADDR_WIDTH  - byte address width of the dmem bus
//   DATA_WIDTH  - dmem data width (one word, four byte lanes)
//   dmem_state_e - DM_IDLE / DM_WAIT / DM_DONE states of dmem_responder
package riscv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned ADDR_WIDTH = XLEN;
    localparam int unsigned DATA_WIDTH = XLEN;

    typedef enum logic [1:0] {
        DM_IDLE,
        DM_WAIT,
        DM_DONE
    } dmem_state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: data-memory bus between the MEM stage (master) and the
// data-memory responder (slave).
//   dmem_req      master->slave  access pending
//   dmem_addr     master->slave  byte address
//   dmem_wen      master->slave  1 = store, 0 = load
//   dmem_byte_en  master->slave  byte lanes to write
//   dmem_wdata    master->slave  lane-aligned store data
//   dmem_rdata    slave->master  full aligned load word
//   dmem_ready    slave->master  access completes this cycle
//   dmem_err      slave->master  word index out of range (with ready)
interface dmem_responder_if;
    import riscv_pkg::*;

    logic                  dmem_req;
    logic [ADDR_WIDTH-1:0] dmem_addr;
    logic                  dmem_wen;
    logic [3:0]            dmem_byte_en;
    logic [DATA_WIDTH-1:0] dmem_wdata;
    logic [DATA_WIDTH-1:0] dmem_rdata;
    logic                  dmem_ready;
    logic                  dmem_err;

    modport master (
        output dmem_req, dmem_addr, dmem_wen, dmem_byte_en, dmem_wdata,
        input  dmem_rdata, dmem_ready, dmem_err
    );

    modport slave (
        input  dmem_req, dmem_addr, dmem_wen, dmem_byte_en, dmem_wdata,
        output dmem_rdata, dmem_ready, dmem_err
    );

endinterface

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x 32-bit data storage with four byte-lane write enables
// and a registered read port. Contents are not reset.
//   clk      core clock, rising edge
//   idx      word index shared by read and write
//   rd_en    capture mem[idx] into rd_data at the edge
//   rd_data  registered read word
//   wr_en    write enable for the lanes selected by byte_en
//   byte_en  per-lane write enables
//   wr_data  lane-aligned write data
module dmem_array
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter string       INIT_FILE = "",
  parameter int unsigned IDX_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic [IDX_W-1:0]      idx,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [3:0]            byte_en,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[idx];
    if (wr_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: slave end of the dmem bus. Accepts one load/store at a
// time, inserts WAIT_CYCLES wait states and completes each access with a
// single-cycle dmem_ready pulse (dmem_err set for word index >= DEPTH).
//   clk    core clock, rising edge
//   rst_n  asynchronous active-low reset
//   dmem   dmem_responder_if slave modport (request/response bus)
module dmem_responder
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter string       INIT_FILE   = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_responder_if.slave   dmem
);

    localparam int unsigned           IDX_W     = $clog2(DEPTH);
    localparam logic [3:0]            WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [ADDR_WIDTH-3:0] DEPTH_IDX = (ADDR_WIDTH-2)'(DEPTH);

    dmem_state_e           state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-3:0] word_idx;
    logic                  out_of_range;
    logic                  rd_en;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  unused_addr_lsb;

    // Alignment is carried by the byte enables; the low address bits are dropped.
    assign unused_addr_lsb = &{1'b0, dmem.dmem_addr[1:0]};
    assign word_idx        = dmem.dmem_addr[ADDR_WIDTH-1:2];
    assign out_of_range    = (word_idx >= DEPTH_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DM_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rd_en   = 1'b0;
        unique case (state_q)
            DM_IDLE: begin
                if (dmem.dmem_req) begin
                    cnt_d   = WAIT_INIT;
                    rd_en   = 1'b1;
                    err_d   = out_of_range;
                    state_d = (WAIT_CYCLES > 0) ? DM_WAIT : DM_DONE;
                end
            end
            DM_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (!dmem.dmem_req) begin
                    state_d = DM_IDLE;
                end else if (cnt_q == 4'd1) begin
                    rd_en   = 1'b1;
                    err_d   = out_of_range;
                    state_d = DM_DONE;
                end
            end
            DM_DONE: state_d = DM_IDLE;
            default: state_d = DM_IDLE;
        endcase
    end

    // A store commits only on the edge that closes DONE; an asynchronous reset
    // before that edge forces IDLE and so suppresses the write.
    assign wr_en = (state_q == DM_DONE) && dmem.dmem_wen && !err_q;

    dmem_array #(
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE),
        .IDX_W     (IDX_W)
    ) u_array (
        .clk     (clk),
        .idx     (word_idx[IDX_W-1:0]),
        .rd_en   (rd_en),
        .rd_data (rdata_q),
        .wr_en   (wr_en),
        .byte_en (dmem.dmem_byte_en),
        .wr_data (dmem.dmem_wdata)
    );

    // The array's read register has no reset, so the word is gated by the
    // state register: zero after reset, outside DONE and for out-of-range.
    assign dmem.dmem_ready = (state_q == DM_DONE);
    assign dmem.dmem_err   = (state_q == DM_DONE) && err_q;
    assign dmem.dmem_rdata = ((state_q == DM_DONE) && !err_q) ? rdata_q : '0;

endmodule
